event_pulse_gen: RTL and testbench

Conditions a raw, asynchronous event input into clean single-cycle `increment_o` pulses for the event counter that sits directly downstream. The block first synchronises the input, then debounces it over a programmable window, then detects edges. It drives the counter's increment input. It also exposes the debounced level and a qualification-in-progress flag for status logic.

---
 rtl/event_pulse_gen.sv | 110 +++++++++++
 tb/tb_event_pulse_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/event_pulse_gen.sv
// Event input conditioner: synchroniser, debounce FSM and registered edge pulse
// that drives the increment input of the downstream event counter.
module event_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable_i,
  input  logic event_i,
  output logic increment_o,
  output logic level_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO,
    QUAL_HI,
    IDLE_HI,
    QUAL_LO
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   accept;
  logic                   pulse_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], event_i};
    end
  end

  assign s       = sync[SYNC_STAGES-1];
  assign level_o = (state == IDLE_HI) || (state == QUAL_LO);
  assign busy_o  = (state == QUAL_HI) || (state == QUAL_LO);

  // cnt holds how many consecutive samples have disagreed with level_o so far.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE_LO, IDLE_HI: begin
        cnt_d = '0;
        if (s != level_o) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = (state == IDLE_LO) ? IDLE_HI : IDLE_LO;
          end else begin
            state_d = (state == IDLE_LO) ? QUAL_HI : QUAL_LO;
            cnt_d   = CW'(1);
          end
        end
      end
      QUAL_HI, QUAL_LO: begin
        if (s == level_o) begin
          state_d = (state == QUAL_HI) ? IDLE_LO : IDLE_HI;
          cnt_d   = '0;
        end else if (cnt >= CNT_LAST) begin
          accept  = 1'b1;
          state_d = (state == QUAL_HI) ? IDLE_HI : IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // An accepted change always moves away from the current level, so a low
  // level_o on the accepting edge means a rising edge.
  always_comb begin
    pulse_d = 1'b0;
    if (accept && enable_i) begin
      if (EDGE_MODE == 2) begin
        pulse_d = 1'b1;
      end else if (EDGE_MODE == 1) begin
        pulse_d = level_o;
      end else begin
        pulse_d = ~level_o;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE_LO;
      cnt         <= '0;
      increment_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      increment_o <= pulse_d;
    end
  end

endmodule

// File: tb/tb_event_pulse_gen.sv
// Bench for event_pulse_gen: three instances (one per edge mode) share stimulus;
// directed segment table plus random bursts against a run-length reference model.
module tb_event_pulse_gen;

  localparam int SYNC = 2;
  localparam int DB   = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic enable_i = 1'b1;
  logic event_i = 1'b0;
  logic [2:0] inc;
  logic [2:0] lvl;
  logic [2:0] bsy;

  int total = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  event_pulse_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .event_i(event_i),
    .increment_o(inc[0]), .level_o(lvl[0]), .busy_o(bsy[0]));
  event_pulse_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .event_i(event_i),
    .increment_o(inc[1]), .level_o(lvl[1]), .busy_o(bsy[1]));
  event_pulse_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(2)) dut2 (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .event_i(event_i),
    .increment_o(inc[2]), .level_o(lvl[2]), .busy_o(bsy[2]));

  // Reference: the level flips once DB consecutive synchronised samples disagree with it.
  int         mq[$];
  int         run = 0;
  logic       m_level = 1'b0;
  logic [2:0] m_inc = 3'b000;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       en;
    logic       ev;
    logic       exp_level;
    logic       exp_busy;
    logic [2:0] exp_inc;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int c, input logic r, input logic e, input logic v,
                        input logic l, input logic b, input logic [2:0] i);
    vec_t t;
    t.cycles = c; t.rst = r; t.en = e; t.ev = v;
    t.exp_level = l; t.exp_busy = b; t.exp_inc = i;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic modelEdge(input logic r, input logic e, input logic v);
    int  sv;
    bit  rising;
    if (r) begin
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(0);
      run = 0;
      m_level = 1'b0;
      m_inc = 3'b000;
    end else begin
      sv = mq.pop_front();
      mq.push_back(int'(v));
      m_inc = 3'b000;
      if (sv != int'(m_level)) begin
        run++;
        if (run == DB) begin
          rising = (sv == 1);
          m_inc[0] = e && rising;
          m_inc[1] = e && !rising;
          m_inc[2] = e;
          m_level = rising;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v);
    RST = r;
    enable_i = e;
    event_i = v;
    @(posedge CLK);
    modelEdge(r, e, v);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("model level m%0d", k), lvl[k], m_level);
      checkOutput($sformatf("model busy m%0d", k), bsy[k], run != 0);
      checkOutput($sformatf("model inc m%0d", k), inc[k], m_inc[k]);
    end
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) mq.push_back(0);

    // reset and idle
    addVec(3, 1, 1, 0, 0, 0, 3'b000);
    addVec(50, 0, 1, 0, 0, 0, 3'b000);
    // clean rise, hold, fall
    addVec(2, 0, 1, 1, 0, 0, 3'b000);
    addVec(1, 0, 1, 1, 0, 1, 3'b000);
    addVec(14, 0, 1, 1, 0, 1, 3'b000);
    addVec(1, 0, 1, 1, 1, 0, 3'b101);
    addVec(1, 0, 1, 1, 1, 0, 3'b000);
    addVec(10, 0, 1, 1, 1, 0, 3'b000);
    addVec(17, 0, 1, 0, 1, 1, 3'b000);
    addVec(1, 0, 1, 0, 0, 0, 3'b110);
    addVec(1, 0, 1, 0, 0, 0, 3'b000);
    addVec(5, 0, 1, 0, 0, 0, 3'b000);
    // 15-cycle glitch rejected
    addVec(15, 0, 1, 1, 0, 1, 3'b000);
    addVec(2, 0, 1, 0, 0, 1, 3'b000);
    addVec(1, 0, 1, 0, 0, 0, 3'b000);
    addVec(5, 0, 1, 0, 0, 0, 3'b000);
    // 16-cycle high accepted, then falls back
    addVec(16, 0, 1, 1, 0, 1, 3'b000);
    addVec(1, 0, 1, 0, 0, 1, 3'b000);
    addVec(1, 0, 1, 0, 1, 0, 3'b101);
    addVec(16, 0, 1, 0, 0, 0, 3'b110);
    addVec(1, 0, 1, 0, 0, 0, 3'b000);
    // enable low through the rise
    addVec(18, 0, 0, 1, 1, 0, 3'b000);
    addVec(2, 0, 0, 1, 1, 0, 3'b000);
    addVec(18, 0, 1, 0, 0, 0, 3'b110);
    addVec(1, 0, 1, 0, 0, 0, 3'b000);
    // enable high only on the accepting edge
    addVec(17, 0, 0, 1, 0, 1, 3'b000);
    addVec(1, 0, 1, 1, 1, 0, 3'b101);
    addVec(1, 0, 0, 1, 1, 0, 3'b000);
    addVec(18, 0, 0, 0, 0, 0, 3'b000);
    addVec(2, 0, 1, 0, 0, 0, 3'b000);
    // reset on edge 10 of a rise
    addVec(9, 0, 1, 1, 0, 1, 3'b000);
    addVec(1, 1, 1, 1, 0, 0, 3'b000);
    addVec(17, 0, 1, 1, 0, 1, 3'b000);
    addVec(1, 0, 1, 1, 1, 0, 3'b101);
    addVec(1, 0, 1, 1, 1, 0, 3'b000);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].ev);
      end
      checkOutput($sformatf("vec%0d level", v), lvl[0], vecs[v].exp_level);
      checkOutput($sformatf("vec%0d busy", v), bsy[0], vecs[v].exp_busy);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("vec%0d inc m%0d", v, k), inc[k], vecs[v].exp_inc[k]);
      end
    end

    // random bursts of varying length with sporadic enable drops and resets
    for (int b = 0; b < 80; b++) begin
      logic ev;
      int   len;
      ev  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), ev);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
